// File: rtl/draw_image_pkg.sv
// Shared VGA constants for the draw_* pipeline stages.
// Counter, colour and ROM address widths live here.
package draw_image_pkg;

  localparam int CNT_W  = 11;
  localparam int RGB_W  = 12;
  localparam int ADDR_W = 20;
  localparam int CMP_W  = CNT_W + 1;
  localparam int REL_W  = ADDR_W / 2;
  localparam int TIM_W  = 2 * CNT_W + 4 + RGB_W;

endpackage

// File: rtl/draw_image_delay.sv
// Fixed-latency shift register for the timing/colour bundle.
// Every stage clears asynchronously so no stale data survives reset.
module delay #(
  parameter int WIDTH   = 38,
  parameter int CLK_DEL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [CLK_DEL];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < CLK_DEL; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_image.sv
// Overlays a ROM image on the VGA stream at a per-frame position.
// Three-clock pipeline: address, ROM read, composite.
module draw_image
  import draw_image_pkg::*;
#(
  parameter int               IMG_W   = 1024,
  parameter int               IMG_H   = 768,
  parameter bit               KEY_EN  = 1'b1,
  parameter logic [RGB_W-1:0] KEY_RGB = 12'hF0F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  hcount_in,
  input  logic [CNT_W-1:0]  vcount_in,
  input  logic              hsync_in,
  input  logic              hblnk_in,
  input  logic              vsync_in,
  input  logic              vblnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic [CNT_W-1:0]  xpos,
  input  logic [CNT_W-1:0]  ypos,
  input  logic [RGB_W-1:0]  rgb_pixel,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [CNT_W-1:0]  hcount_out,
  output logic [CNT_W-1:0]  vcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic              vsync_out,
  output logic              vblnk_out,
  output logic [RGB_W-1:0]  rgb_out
);

  localparam logic [CMP_W-1:0] W_EXT = CMP_W'(IMG_W);
  localparam logic [CMP_W-1:0] H_EXT = CMP_W'(IMG_H);

  logic             vblnk_prev;
  logic [CNT_W-1:0] xpos_lat;
  logic [CNT_W-1:0] ypos_lat;

  // Position is only taken at the start of vertical blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_prev <= 1'b0;
      xpos_lat   <= '0;
      ypos_lat   <= '0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) begin
        xpos_lat <= xpos;
        ypos_lat <= ypos;
      end
    end
  end

  logic [CMP_W-1:0] h_ext, v_ext;
  logic [CMP_W-1:0] x_ext, y_ext;
  logic             in_img_c;
  logic [REL_W-1:0] rel_x, rel_y;

  assign h_ext = {1'b0, hcount_in};
  assign v_ext = {1'b0, vcount_in};
  assign x_ext = {1'b0, xpos_lat};
  assign y_ext = {1'b0, ypos_lat};

  // One extra bit keeps right/bottom edges from wrapping.
  assign in_img_c = (h_ext >= x_ext) && (h_ext < x_ext + W_EXT)
                 && (v_ext >= y_ext) && (v_ext < y_ext + H_EXT)
                 && !hblnk_in && !vblnk_in;

  assign rel_x = hcount_in[REL_W-1:0] - xpos_lat[REL_W-1:0];
  assign rel_y = vcount_in[REL_W-1:0] - ypos_lat[REL_W-1:0];

  logic             in_img_s1;
  logic             in_img_s2;
  logic             use_px;
  logic [RGB_W-1:0] px_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_addr <= '0;
      in_img_s1  <= 1'b0;
      in_img_s2  <= 1'b0;
      use_px     <= 1'b0;
      px_s3      <= '0;
    end else begin
      pixel_addr <= in_img_c ? {rel_y, rel_x} : '0;
      in_img_s1  <= in_img_c;
      in_img_s2  <= in_img_s1;
      use_px     <= in_img_s2
                 && !(KEY_EN && (rgb_pixel == KEY_RGB));
      px_s3      <= rgb_pixel;
    end
  end

  logic [TIM_W-1:0] tim_d;
  logic [RGB_W-1:0] rgb_d;

  delay #(
    .WIDTH   (TIM_W),
    .CLK_DEL (3)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({hcount_in, vcount_in, hsync_in, hblnk_in,
            vsync_in, vblnk_in, rgb_in}),
    .dout (tim_d)
  );

  assign {hcount_out, vcount_out, hsync_out, hblnk_out,
          vsync_out, vblnk_out, rgb_d} = tim_d;

  // Final select reads only stage-3 registers.
  assign rgb_out = (hblnk_out || vblnk_out) ? '0
                 : use_px                   ? px_s3
                 :                            rgb_d;

endmodule

// File: doc/draw_image.md
DRAW_IMAGE -- requirements
Module: draw_image

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  - IMG_W, 1024, image width in pixels
  - IMG_H, 768, image height in pixels
  - KEY_EN, 1, enables transparent key colour
  - KEY_RGB, 12'hF0F, key colour treated as transparent
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk, in, 1: pixel clock
  - rst, in, 1: asynchronous active-high reset
  - hcount_in, in, 11: horizontal pixel counter
  - vcount_in, in, 11: vertical line counter
  - hsync_in, in, 1: horizontal sync
  - hblnk_in, in, 1: horizontal blank
  - vsync_in, in, 1: vertical sync
  - vblnk_in, in, 1: vertical blank
  - rgb_in, in, 12: upstream pixel colour
  - xpos, in, 11: image left edge, screen pixels
  - ypos, in, 11: image top edge, screen lines
  - rgb_pixel, in, 12: image ROM data, valid one clk after address
  - pixel_addr, out, 20: image ROM address {rel_y[9:0], rel_x[9:0]}
  - hcount_out, out, 11: delayed hcount_in
  - vcount_out, out, 11: delayed vcount_in
  - hsync_out, out, 1: delayed hsync_in
  - hblnk_out, out, 1: delayed hblnk_in
  - vsync_out, out, 1: delayed vsync_in
  - vblnk_out, out, 1: delayed vblnk_in
  - rgb_out, out, 12: composited pixel colour

Function
REQ-003 xpos/ypos SHALL be sampled into xpos_lat/ypos_lat only on the clk where vblnk_in is 1 and was 0 on the previous clk; positions SHALL stay constant for the whole visible frame.
REQ-004 Stage 1 (edge 1) SHALL register pixel_addr, an in_img flag and the timing/rgb_in inputs.
REQ-005 in_img SHALL be 1 iff all of the following hold, using 12-bit unsigned compares with no wrap:
  - hcount_in >= xpos_lat and hcount_in < xpos_lat+IMG_W
  - vcount_in >= ypos_lat and vcount_in < ypos_lat+IMG_H
  - hblnk_in=0 and vblnk_in=0
REQ-006 pixel_addr SHALL be {vcount_in-ypos_lat, hcount_in-xpos_lat}, each truncated to 10 bits, when in_img=1, else 20'h0.
REQ-007 Stage 2 (edge 2) SHALL carry stage-1 flag/timing/rgb_in, aligned with rgb_pixel returned by the ROM.
REQ-008 Stage 3 (edge 3) SHALL register all outputs, giving a fixed latency of exactly 3 clk from any input to its corresponding output.
REQ-009 rgb_out selection:
  - blanking (delayed hblnk or vblnk = 1): rgb_out SHALL be 12'h000.
  - otherwise, if in_img=1 and not (KEY_EN=1 and rgb_pixel==KEY_RGB): rgb_out SHALL be rgb_pixel.
  - otherwise: rgb_out SHALL be the delayed rgb_in.
REQ-010 Sync/blank/count outputs SHALL equal the inputs delayed 3 clk, unmodified.
REQ-011 Boundary cases:
  - image partly off-screen right/bottom: only the visible part drawn, no wrap.
  - xpos_lat+IMG_W > 2047: compare in 12 bits.
  - xpos/ypos change mid-frame: ignored until the next vblnk rising edge.

Reset
REQ-012 While rst=1 (asynchronous assert), the following SHALL be 0:
  - all outputs, including pixel_addr and rgb_out
  - all pipeline registers
  - xpos_lat, ypos_lat, and the vblnk edge-detect register
REQ-013 After rst deasserts, the first valid output SHALL appear 3 clk after the first sampled input; positions remain 0 until the first vblnk rising edge.
REQ-014 Reset asserted mid-line SHALL clear the pipeline immediately; no stale pixel SHALL emerge after release.

Structure
REQ-015 VGA counter width (11), colour width (12) and ROM address width (20) SHALL be constants in the shared VGA constants header used by all draw_* stages.
REQ-016 The 3-stage timing path SHALL use one sub-module, delay (parameters WIDTH, CLK_DEL), instantiated with WIDTH=38, CLK_DEL=3 for {hcount, vcount, hsync, hblnk, vsync, vblnk, rgb_in}.

Verification
REQ-017 Latency: xpos=ypos=0, ROM model returns addr[11:0]; pixel (h=5, v=2) -> pixel_addr=20'h00805 at edge 1, rgb_out=12'h805 at edge 3.
REQ-018 Offset/region: xpos=100, ypos=50 latched, IMG_W=64, IMG_H=48. Required responses:
  - h=99 -> rgb_in passed.
  - h=100, v=50 -> pixel_addr=0.
  - h=163, v=97 -> pixel_addr={10'd47, 10'd63}.
  - h=164 -> rgb_in passed.
REQ-019 Transparency: ROM returns 12'hF0F inside region, rgb_in=12'h123 -> rgb_out=12'h123; KEY_EN=0 -> rgb_out=12'hF0F.
REQ-020 Position latch: xpos changed 0 -> 200 mid-frame -> same frame unchanged; after the next vblnk rising edge, the image starts at h=200.
REQ-021 Blanking/reset: hblnk_in=1 inside region -> rgb_out=0, pixel_addr=0. rst pulse mid-line -> all outputs 0 the same cycle; outputs resume exactly 3 clk after release.
